// File: rtl/mfm_write_encoder_pkg.sv
// Shared floppy write-side definitions: sync constants, FSM and precompensation enums,
// and the precompensation classifier used by the pulse generator.
package mfm_write_encoder_pkg;

  localparam logic [7:0]  MFM_SYNC_BYTE  = 8'hA1;
  localparam logic [15:0] MFM_SYNC_CELLS = 16'h4489;
  // Data bit whose preceding clock cell is dropped to form the missing-clock sync mark.
  localparam int          MFM_SYNC_DATA_BIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } wr_state_e;

  typedef enum logic [1:0] {
    EARLY,
    NOM,
    LATE
  } precomp_e;

  function automatic precomp_e precomp_class(input logic en, input logic c_m2, input logic c_p2);
    if (en && c_m2 && !c_p2) return EARLY;
    if (en && !c_m2 && c_p2) return LATE;
    return NOM;
  endfunction

endpackage

// File: rtl/mfm_write_encoder_if.sv
// Byte handshake between the write FIFO/sequencer (master) and the MFM encoder (slave).
interface mfm_write_encoder_if;

  logic [7:0] DATA_IN;
  logic       SYNC_MARK;
  logic       DATA_VALID;
  logic       DATA_READY;

  modport master (
    output DATA_IN,
    output SYNC_MARK,
    output DATA_VALID,
    input  DATA_READY
  );

  modport slave (
    input  DATA_IN,
    input  SYNC_MARK,
    input  DATA_VALID,
    output DATA_READY
  );

endinterface

// File: rtl/mfm_write_encoder_cell_encoder.sv
// Combinational MFM byte encoder: 8 data bits (MSB first) -> 16 half-cells, clock cell first.
module mfm_cell_encoder
  import mfm_write_encoder_pkg::*;
(
  input  logic [7:0]  data_byte,
  input  logic        prev_bit,
  input  logic        sync_mark,
  output logic [15:0] cells,
  output logic        last_bit
);

  logic prev_chain;

  always_comb begin
    cells      = '0;
    prev_chain = prev_bit;
    for (int i = 7; i >= 0; i--) begin
      cells[2*i+1] = ~prev_chain & ~data_byte[i] & ~(sync_mark && (i == MFM_SYNC_DATA_BIT));
      cells[2*i]   = data_byte[i];
      prev_chain   = data_byte[i];
    end
  end

  assign last_bit = data_byte[0];

endmodule

// File: rtl/mfm_write_encoder.sv
// MFM write encoder: accepts bytes on a valid/ready bus, emits precompensated flux pulses
// on FD_WRDATA and frames the stream with FD_WRGATE.
module mfm_write_encoder
  import mfm_write_encoder_pkg::*;
#(
  parameter int CELL_CLKS    = 16,
  parameter int PULSE_CLKS   = 4,
  parameter int PRECOMP_CLKS = 2
) (
  input  logic                   MASTER_CLK,
  input  logic                   nRESET,
  input  logic                   ENABLE,
  input  logic                   PRECOMP_EN,
  mfm_write_encoder_if.slave     wr_bus,
  output logic                   FD_WRDATA,
  output logic                   FD_WRGATE,
  output logic                   BUSY,
  output logic                   UNDERRUN
);

  if (PULSE_CLKS + 2*PRECOMP_CLKS >= CELL_CLKS) begin : g_bad_timing
    $error("mfm_write_encoder: PULSE_CLKS + 2*PRECOMP_CLKS must be less than CELL_CLKS");
  end

  localparam int             TMR_W    = $clog2(CELL_CLKS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CELL_CLKS - 1);

  function automatic int pulse_offset(input precomp_e sel);
    case (sel)
      EARLY:   return 0;
      LATE:    return 2*PRECOMP_CLKS;
      default: return PRECOMP_CLKS;
    endcase
  endfunction

  wr_state_e        state;
  logic [TMR_W-1:0] tmr;
  logic [3:0]       hc;
  logic [1:0]       drain_cnt;
  logic             prev_bit;
  logic             hold_full;
  logic             last_byte;
  logic [7:0]       hold_byte;
  logic             hold_sync;
  logic [15:0]      cur_cells;
  logic [3:0]       cell_hist_p0;

  logic [7:0]  enc_byte;
  logic        enc_prev;
  logic        enc_sync;
  logic [15:0] enc_cells;
  logic        enc_last;

  logic        handshake;
  logic        at_wrap;
  logic        byte_end;
  logic        deadline;
  logic        gen_cell;
  precomp_e    pc_sel;
  int          pulse_off;
  logic        pulse_on;

  assign enc_byte = (state == IDLE) ? wr_bus.DATA_IN   : hold_byte;
  assign enc_prev = (state == IDLE) ? 1'b0             : prev_bit;
  assign enc_sync = (state == IDLE) ? wr_bus.SYNC_MARK : hold_sync;

  mfm_cell_encoder u_cell_encoder (
    .data_byte (enc_byte),
    .prev_bit  (enc_prev),
    .sync_mark (enc_sync),
    .cells     (enc_cells),
    .last_bit  (enc_last)
  );

  assign wr_bus.DATA_READY = ENABLE &
                             ((state == IDLE) | ((state == RUN) & ~hold_full & ~last_byte));
  assign handshake = wr_bus.DATA_VALID & wr_bus.DATA_READY;
  assign BUSY      = (state != IDLE);

  // The timer leads the pin timing by one clock so FD_WRDATA can be a plain register;
  // tmr==0 of half-cell 14 is therefore the last pin-visible cycle of half-cell 13.
  assign at_wrap  = (tmr == TMR_LAST);
  assign byte_end = at_wrap && (hc == 4'd15);
  assign deadline = (hc == 4'd14) && (tmr == '0);

  // cell_hist_p0 holds the four cells before the one being generated; the emitted cell
  // is two periods old, so its +/-2 neighbours are the generated cell and the oldest entry.
  assign gen_cell  = (state == RUN) ? cur_cells[4'd15 - hc] : 1'b0;
  assign pc_sel    = precomp_class(PRECOMP_EN, cell_hist_p0[3], gen_cell);
  assign pulse_off = pulse_offset(pc_sel);
  assign pulse_on  = (state != IDLE) && cell_hist_p0[1] &&
                     (int'(tmr) >= pulse_off) && (int'(tmr) < pulse_off + PULSE_CLKS);

  always_ff @(posedge MASTER_CLK or negedge nRESET) begin
    if (!nRESET) begin
      state        <= IDLE;
      tmr          <= '0;
      hc           <= '0;
      drain_cnt    <= '0;
      prev_bit     <= 1'b0;
      hold_full    <= 1'b0;
      last_byte    <= 1'b0;
      cell_hist_p0 <= '0;
      FD_WRDATA    <= 1'b0;
      FD_WRGATE    <= 1'b0;
      UNDERRUN     <= 1'b0;
    end else begin
      UNDERRUN  <= 1'b0;
      FD_WRDATA <= pulse_on;
      case (state)
        IDLE: begin
          if (handshake) begin
            state        <= RUN;
            FD_WRGATE    <= 1'b1;
            tmr          <= TMR_W'(1);
            hc           <= '0;
            prev_bit     <= enc_last;
            hold_full    <= 1'b0;
            last_byte    <= 1'b0;
            cell_hist_p0 <= '0;
          end
        end
        RUN: begin
          tmr <= at_wrap ? '0 : tmr + 1'b1;
          if (at_wrap) begin
            hc           <= hc + 4'd1;
            cell_hist_p0 <= {cell_hist_p0[2:0], gen_cell};
          end
          if (handshake) hold_full <= 1'b1;
          if (deadline && !hold_full && !handshake) last_byte <= 1'b1;
          if (byte_end) begin
            if (last_byte) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              prev_bit  <= enc_last;
              hold_full <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) begin
            state     <= IDLE;
            FD_WRGATE <= 1'b0;
            UNDERRUN  <= ENABLE;
          end else begin
            tmr <= at_wrap ? '0 : tmr + 1'b1;
            if (at_wrap) begin
              drain_cnt    <= drain_cnt + 2'd1;
              cell_hist_p0 <= {cell_hist_p0[2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte payload registers carry no reset; their use is qualified by the FSM.
  always_ff @(posedge MASTER_CLK) begin
    if ((state == IDLE && handshake) || (state == RUN && byte_end && !last_byte)) begin
      cur_cells <= enc_cells;
    end
    if (state == RUN && handshake) begin
      hold_byte <= wr_bus.DATA_IN;
      hold_sync <= wr_bus.SYNC_MARK;
    end
  end

endmodule

// File: tb/tb_mfm_write_encoder.sv
// Directed bench for mfm_write_encoder: reconstructs the cell stream from FD_WRDATA pulse
// timing and compares it with hand-encoded MFM words and precompensation offsets.
module tb_mfm_write_encoder;
  import mfm_write_encoder_pkg::*;

  logic MASTER_CLK = 1'b0;
  logic nRESET     = 1'b0;
  logic ENABLE     = 1'b0;
  logic PRECOMP_EN = 1'b0;
  logic FD_WRDATA, FD_WRGATE, BUSY, UNDERRUN;

  mfm_write_encoder_if bus();

  mfm_write_encoder #(
    .CELL_CLKS    (16),
    .PULSE_CLKS   (4),
    .PRECOMP_CLKS (2)
  ) dut (
    .MASTER_CLK (MASTER_CLK),
    .nRESET     (nRESET),
    .ENABLE     (ENABLE),
    .PRECOMP_EN (PRECOMP_EN),
    .wr_bus     (bus),
    .FD_WRDATA  (FD_WRDATA),
    .FD_WRGATE  (FD_WRGATE),
    .BUSY       (BUSY),
    .UNDERRUN   (UNDERRUN)
  );

  always #5 MASTER_CLK = ~MASTER_CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  // Stream monitor, restarted on every FD_WRGATE rise.
  logic gate_q = 1'b0;
  logic wr_q   = 1'b0;
  int   rel, gate_len, und_cnt, wcnt, wmin, wmax, npulse;
  int   pstart [0:63];
  logic cellbits [0:63];
  int   cofs [0:63];

  always @(negedge MASTER_CLK) begin
    if (FD_WRGATE && !gate_q) begin
      rel = 0; gate_len = 0; und_cnt = 0; wmin = 999; wmax = 0; npulse = 0;
      for (int i = 0; i < 64; i++) begin
        cellbits[i] = 1'b0; cofs[i] = -1; pstart[i] = -1;
      end
    end else if (FD_WRGATE) begin
      rel++;
    end
    if (FD_WRGATE) gate_len++;
    if (FD_WRDATA && !wr_q) begin
      if (npulse < 64) pstart[npulse] = rel;
      npulse++;
      if ((rel / 16 - 2) >= 0 && (rel / 16 - 2) < 64) begin
        cellbits[rel / 16 - 2] = 1'b1;
        cofs[rel / 16 - 2]     = rel % 16;
      end
      wcnt = 1;
    end else if (FD_WRDATA) begin
      wcnt++;
    end
    if (!FD_WRDATA && wr_q) begin
      if (wcnt < wmin) wmin = wcnt;
      if (wcnt > wmax) wmax = wcnt;
    end
    if (UNDERRUN) und_cnt++;
    gate_q = FD_WRGATE;
    wr_q   = FD_WRDATA;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cell_word(input int n);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = cellbits[16*n + i];
    return w;
  endfunction

  // Present a byte (called at a negedge) and return on the negedge after it is taken.
  task automatic push(input string tag, input logic [7:0] d, input logic s);
    logic ok;
    ok = 1'b0;
    bus.DATA_IN    = d;
    bus.SYNC_MARK  = s;
    bus.DATA_VALID = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      #1;
      if (bus.DATA_READY) ok = 1'b1;
      @(negedge MASTER_CLK);
    end
    if (ok) hs_cnt++;
    chk({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    do begin
      @(negedge MASTER_CLK); #1; i++;
    end while (BUSY && i < 5000);
    chk({tag, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int bad;
    bus.DATA_IN    = 8'h00;
    bus.SYNC_MARK  = 1'b0;
    bus.DATA_VALID = 1'b0;

    // Reset state, and no acceptance while ENABLE is low.
    repeat (3) @(negedge MASTER_CLK);
    nRESET = 1'b1;
    bus.DATA_VALID = 1'b1;
    repeat (4) @(negedge MASTER_CLK);
    #1;
    chk("rst_wrdata", 32'(FD_WRDATA), 0);
    chk("rst_wrgate", 32'(FD_WRGATE), 0);
    chk("rst_busy",   32'(BUSY), 0);
    chk("rst_underrun", 32'(UNDERRUN), 0);
    chk("rst_ready",  32'(bus.DATA_READY), 0);
    bus.DATA_VALID = 1'b0;
    @(negedge MASTER_CLK);

    // 1: single 0x00, nominal timing.
    ENABLE = 1'b1;
    push("t1", 8'h00, 1'b0);
    bus.DATA_VALID = 1'b0;
    wait_idle("t1");
    chk("t1_npulse", 32'(npulse), 8);
    for (int k = 0; k < 8; k++) chk($sformatf("t1_pulse%0d", k), 32'(pstart[k]), 32'(34 + 32*k));
    chk("t1_wmin", 32'(wmin), 4);
    chk("t1_wmax", 32'(wmax), 4);
    chk("t1_gate", 32'(gate_len), 288);
    chk("t1_word", 32'(cell_word(0)), 32'h0000AAAA);
    repeat (2) @(negedge MASTER_CLK);
    chk("t1_underrun", 32'(und_cnt), 1);

    // 2: sync A1 followed by plain A1, back to back.
    push("t2a", MFM_SYNC_BYTE, 1'b1);
    push("t2b", 8'hA1, 1'b0);
    bus.DATA_VALID = 1'b0;
    wait_idle("t2");
    chk("t2_word0", 32'(cell_word(0)), 32'(MFM_SYNC_CELLS));
    chk("t2_word1", 32'(cell_word(1)), 32'h000044A9);
    chk("t2_gate", 32'(gate_len), 34*16);

    // 3: 0x0F with precompensation.
    PRECOMP_EN = 1'b1;
    push("t3", 8'h0F, 1'b0);
    bus.DATA_VALID = 1'b0;
    wait_idle("t3");
    chk("t3_word", 32'(cell_word(0)), 32'h0000AA55);
    chk("t3_ofs0", 32'(cofs[0]), 4);
    chk("t3_ofs2", 32'(cofs[2]), 2);
    chk("t3_ofs6", 32'(cofs[6]), 0);
    chk("t3_ofs9", 32'(cofs[9]), 4);
    chk("t3_ofs15", 32'(cofs[15]), 0);
    chk("t3_gate", 32'(gate_len), 288);
    PRECOMP_EN = 1'b0;

    // 4: three bytes with DATA_VALID held throughout.
    hs_cnt = 0;
    push("t4a", 8'h00, 1'b0);
    push("t4b", 8'hFF, 1'b0);
    push("t4c", 8'h00, 1'b0);
    bus.DATA_VALID = 1'b0;
    wait_idle("t4");
    chk("t4_handshakes", 32'(hs_cnt), 3);
    chk("t4_word0", 32'(cell_word(0)), 32'h0000AAAA);
    chk("t4_word1", 32'(cell_word(1)), 32'h00005555);
    chk("t4_word2", 32'(cell_word(2)), 32'h00002AAA);
    chk("t4_gate", 32'(gate_len), 50*16);
    chk("t4_underrun", 32'(und_cnt), 1);

    // 5: second byte offered after the deadline is held off until IDLE.
    push("t5a", 8'h00, 1'b0);
    bus.DATA_VALID = 1'b0;
    repeat (240) @(negedge MASTER_CLK);
    bus.DATA_IN    = 8'hFF;
    bus.SYNC_MARK  = 1'b0;
    bus.DATA_VALID = 1'b1;
    bad = 0;
    wait_idle("t5a");
    chk("t5_late_underrun", 32'(UNDERRUN), 1);
    chk("t5_gate1", 32'(gate_len), 288);
    chk("t5_word1", 32'(cell_word(0)), 32'h0000AAAA);
    @(negedge MASTER_CLK);
    bus.DATA_VALID = 1'b0;
    #1;
    chk("t5_second_started", 32'(BUSY), 1);
    wait_idle("t5b");
    chk("t5_gate2", 32'(gate_len), 288);
    chk("t5_word2", 32'(cell_word(0)), 32'h00005555);
    chk("t5_underrun2", 32'(und_cnt), 1);

    // 6: ENABLE dropped in half-cell 5.
    push("t6", 8'h5A, 1'b0);
    bus.DATA_VALID = 1'b0;
    repeat (5*16 + 4) @(negedge MASTER_CLK);
    ENABLE = 1'b0;
    bus.DATA_IN    = 8'h33;
    bus.DATA_VALID = 1'b1;
    wait_idle("t6");
    repeat (4) @(negedge MASTER_CLK);
    #1;
    chk("t6_word", 32'(cell_word(0)), 32'h00009144);
    chk("t6_gate", 32'(gate_len), 288);
    chk("t6_underrun", 32'(und_cnt), 0);
    chk("t6_no_restart", 32'(BUSY), 0);
    bus.DATA_VALID = 1'b0;
    ENABLE = 1'b1;
    @(negedge MASTER_CLK);

    // Asynchronous reset in the middle of a flux pulse.
    push("rst_mid", 8'h00, 1'b0);
    bus.DATA_VALID = 1'b0;
    bad = 1;
    for (int i = 0; i < 200 && bad != 0; i++) begin
      @(negedge MASTER_CLK); #1;
      if (FD_WRDATA) bad = 0;
    end
    chk("rst_mid_pulse_seen", 32'(bad), 0);
    #2;
    nRESET = 1'b0;
    #1;
    chk("rst_mid_wrdata", 32'(FD_WRDATA), 0);
    chk("rst_mid_wrgate", 32'(FD_WRGATE), 0);
    chk("rst_mid_busy",   32'(BUSY), 0);
    @(negedge MASTER_CLK);
    nRESET = 1'b1;
    repeat (2) @(negedge MASTER_CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
